// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit nibble writer.
// Timing defaults are CLK cycles at 50 MHz.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_NIB,
        INIT_WAIT,
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        EXEC
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam int DEF_T_PWRUP = 750000;
    localparam int DEF_T_INIT1 = 205000;
    localparam int DEF_T_INIT2 = 5000;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_EPW   = 12;
    localparam int DEF_T_HOLD  = 50;
    localparam int DEF_T_CMD   = 2000;
    localparam int DEF_T_LONG  = 82000;

    // Clear/home commands need the long execution wait
    function automatic logic is_long_cmd(
        input logic       rs,
        input logic [7:0] b
    );
        return !rs && (b == CMD_CLEAR || b == CMD_HOME
                       || b == CMD_HOME_ALT);
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counter shared by every timed phase of the writer.
// Loaded with N-1, done while zero: N cycles per phase.
module lcd_delay_counter #(
    parameter int             W       = 20,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble HD44780 writer with autonomous 4-bit power-up init.
// Upstream sees a Strb/Busy handshake only.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = DEF_T_PWRUP,
    parameter int T_INIT1 = DEF_T_INIT1,
    parameter int T_INIT2 = DEF_T_INIT2,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_EPW   = DEF_T_EPW,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_CMD   = DEF_T_CMD,
    parameter int T_LONG  = DEF_T_LONG
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Strb,
    input  logic [7:0] D_in,
    input  logic       RS,
    output logic       Busy,
    output logic [3:0] D_out,
    output logic       E,
    output logic       RS_out
);

    localparam int CW = cnt_width(T_PWRUP, T_LONG);

    function automatic logic [CW-1:0] ld(input int n);
        return CW'(n - 1);
    endfunction

    lcd_state_t  state;
    logic        in_init;
    logic [1:0]  init_idx;
    logic        nib_lo;
    logic [7:0]  byte_q;
    logic        rs_q;

    logic          load;
    logic [CW-1:0] load_val;
    logic          done;

    lcd_delay_counter #(
        .W       (CW),
        .RST_VAL (CW'(T_PWRUP - 1))
    ) u_dly (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // Reload the counter for whichever phase the FSM enters next
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        unique case (state)
            PWRUP: begin
                if (done) begin
                    load     = 1'b1;
                    load_val = ld(T_SETUP);
                end
            end
            INIT_NIB, SETUP: begin
                if (done) begin
                    load     = 1'b1;
                    load_val = ld(T_EPW);
                end
            end
            EHIGH: begin
                if (done) begin
                    load     = 1'b1;
                    load_val = ld(T_HOLD);
                end
            end
            HOLD: begin
                if (done) begin
                    load = 1'b1;
                    if (in_init)
                        load_val = (init_idx == 2'd0) ? ld(T_INIT1)
                                                      : ld(T_INIT2);
                    else if (!nib_lo)
                        load_val = ld(T_SETUP);
                    else if (is_long_cmd(rs_q, byte_q))
                        load_val = ld(T_LONG);
                    else
                        load_val = ld(T_CMD);
                end
            end
            INIT_WAIT: begin
                if (done && init_idx != 2'd3) begin
                    load     = 1'b1;
                    load_val = ld(T_SETUP);
                end
            end
            IDLE: begin
                if (Strb) begin
                    load     = 1'b1;
                    load_val = ld(T_SETUP);
                end
            end
            EXEC: begin
                load = 1'b0;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= PWRUP;
            in_init  <= 1'b1;
            init_idx <= 2'd0;
            nib_lo   <= 1'b0;
            byte_q   <= 8'h00;
            rs_q     <= 1'b0;
            Busy     <= 1'b1;
            E        <= 1'b0;
            D_out    <= 4'h0;
            RS_out   <= 1'b0;
        end else begin
            unique case (state)
                PWRUP: begin
                    if (done) begin
                        state    <= INIT_NIB;
                        init_idx <= 2'd0;
                        D_out    <= INIT_NIB_8BIT;
                        RS_out   <= 1'b0;
                    end
                end
                INIT_NIB, SETUP: begin
                    if (done) begin
                        state <= EHIGH;
                        E     <= 1'b1;
                    end
                end
                EHIGH: begin
                    if (done) begin
                        state <= HOLD;
                        E     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (done) begin
                        if (in_init) begin
                            state <= INIT_WAIT;
                        end else if (!nib_lo) begin
                            state  <= SETUP;
                            nib_lo <= 1'b1;
                            D_out  <= byte_q[3:0];
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                INIT_WAIT: begin
                    if (done) begin
                        if (init_idx == 2'd3) begin
                            state   <= IDLE;
                            in_init <= 1'b0;
                            Busy    <= 1'b0;
                        end else begin
                            state    <= INIT_NIB;
                            init_idx <= init_idx + 2'd1;
                            D_out    <= (init_idx == 2'd2) ? INIT_NIB_4BIT
                                                           : INIT_NIB_8BIT;
                        end
                    end
                end
                IDLE: begin
                    if (Strb) begin
                        state  <= SETUP;
                        byte_q <= D_in;
                        rs_q   <= RS;
                        nib_lo <= 1'b0;
                        D_out  <= D_in[7:4];
                        RS_out <= RS;
                        Busy   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (done) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer: directed table,
// corner sequences and random bytes against an E-pulse model.
module tb_lcd_nibble_writer;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 8;
    localparam int T_INIT2 = 4;
    localparam int T_SETUP = 2;
    localparam int T_EPW   = 3;
    localparam int T_HOLD  = 4;
    localparam int T_CMD   = 10;
    localparam int T_LONG  = 30;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       Strb = 1'b0;
    logic [7:0] D_in = 8'h00;
    logic       RS = 1'b0;
    logic       Busy;
    logic [3:0] D_out;
    logic       E;
    logic       RS_out;

    lcd_nibble_writer #(
        .T_PWRUP (T_PWRUP),
        .T_INIT1 (T_INIT1),
        .T_INIT2 (T_INIT2),
        .T_SETUP (T_SETUP),
        .T_EPW   (T_EPW),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_LONG  (T_LONG)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .Strb   (Strb),
        .D_in   (D_in),
        .RS     (RS),
        .Busy   (Busy),
        .D_out  (D_out),
        .E      (E),
        .RS_out (RS_out)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observed E pulses: nibble, RS, width, setup cycles, data stability
    typedef struct {
        int nib;
        int rs;
        int width;
        int setup;
        bit stable;
    } pulse_t;

    pulse_t pq[$];

    logic       prev_e = 1'b0;
    logic [4:0] last_bus = 5'h00;
    int         setup_cnt = 0;
    pulse_t     cur;

    always @(posedge CLK) begin
        #2;
        if ({D_out, RS_out} != last_bus)
            setup_cnt = 0;
        else
            setup_cnt++;
        last_bus = {D_out, RS_out};
        if (E && !prev_e) begin
            cur.nib    = D_out;
            cur.rs     = RS_out;
            cur.width  = 1;
            cur.setup  = setup_cnt;
            cur.stable = 1'b1;
        end else if (E && prev_e) begin
            cur.width++;
            if (D_out != cur.nib[3:0] || RS_out != cur.rs[0])
                cur.stable = 1'b0;
        end else if (!E && prev_e) begin
            pq.push_back(cur);
        end
        prev_e = E;
    end

    function automatic int model_busy(input logic [7:0] d, input logic rs);
        int ex;
        ex = (!rs && d >= 8'd1 && d <= 8'd3) ? T_LONG : T_CMD;
        return 2 * (T_SETUP + T_EPW + T_HOLD) + ex;
    endfunction

    task automatic chk_pulse(input int i, input int nib, input int rs);
        if (i < pq.size()) begin
            chk($sformatf("pulse%0d_nib", i), pq[i].nib, nib);
            chk($sformatf("pulse%0d_rs", i), pq[i].rs, rs);
            chk($sformatf("pulse%0d_width", i), pq[i].width, T_EPW);
            chk($sformatf("pulse%0d_setup_ok", i),
                int'(pq[i].setup >= T_SETUP), 1);
            chk($sformatf("pulse%0d_stable", i), int'(pq[i].stable), 1);
        end
    endtask

    // Called at the negedge on which RESET was just released
    task automatic init_check();
        int n;
        int exp_nib [4];
        exp_nib = '{3, 3, 3, 2};
        n = 0;
        while (Busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge CLK);
        end
        chk("init_busy_len", n,
            T_PWRUP + 4 * (T_SETUP + T_EPW + T_HOLD)
            + T_INIT1 + 3 * T_INIT2);
        chk("init_pulse_count", pq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_pulse(i, exp_nib[i], 0);
    endtask

    task automatic write_byte(
        input logic [7:0] d,
        input logic       rs,
        input int         hi,
        input int         lo,
        input int         exp_busy,
        input int         inject
    );
        int n;
        chk("idle_before_strb", Busy, 0);
        pq.delete();
        Strb = 1'b1;
        D_in = d;
        RS   = rs;
        @(negedge CLK);
        Strb = 1'b0;
        D_in = 8'($urandom);
        RS   = 1'($urandom);
        chk("busy_rise", Busy, 1);
        n = 0;
        while (Busy === 1'b1 && n < 2000) begin
            n++;
            if (n == inject) begin
                Strb = 1'b1;
                D_in = 8'hFF;
            end else begin
                Strb = 1'b0;
            end
            @(negedge CLK);
        end
        Strb = 1'b0;
        chk($sformatf("busy_len_%02h", d), n, exp_busy);
        chk("pulse_count", pq.size(), 2);
        chk_pulse(0, hi, rs);
        chk_pulse(1, lo, rs);
        chk("idle_d_out", D_out, lo);
        chk("idle_rs_out", RS_out, rs);
        chk("idle_e", E, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         hi;
        int         lo;
        int         busy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] rd;
        logic       rrs;
        int         k;

        vecs[0] = '{8'h53, 1'b1, 5,  3, 28};
        vecs[1] = '{8'h01, 1'b0, 0,  1, 48};
        vecs[2] = '{8'h02, 1'b0, 0,  2, 48};
        vecs[3] = '{8'h03, 1'b0, 0,  3, 48};
        vecs[4] = '{8'h04, 1'b0, 0,  4, 28};
        vecs[5] = '{8'h01, 1'b1, 0,  1, 28};
        vecs[6] = '{8'h00, 1'b0, 0,  0, 28};
        vecs[7] = '{8'hC0, 1'b0, 12, 0, 28};

        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_busy", Busy, 1);
        chk("rst_e", E, 0);
        chk("rst_d_out", D_out, 0);
        chk("rst_rs_out", RS_out, 0);
        RESET = 1'b0;
        pq.delete();
        init_check();

        // Back-to-back: each write strobes on the first idle cycle
        for (int i = 0; i < 8; i++)
            write_byte(vecs[i].d, vecs[i].rs, vecs[i].hi, vecs[i].lo,
                       vecs[i].busy, -1);

        write_byte(8'h53, 1'b1, 5, 3, 28, 10);
        write_byte(8'h01, 1'b0, 0, 1, 48, 25);

        for (int i = 0; i < 24; i++) begin
            rd  = 8'($urandom);
            rrs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                rd = 8'($urandom_range(0, 4));
            write_byte(rd, rrs, rd / 16, rd % 16, model_busy(rd, rrs),
                       (i % 3 == 0) ? int'($urandom_range(1, 20)) : -1);
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        // Reset while E is high
        Strb = 1'b1;
        D_in = 8'h53;
        RS   = 1'b1;
        @(negedge CLK);
        Strb = 1'b0;
        k = 0;
        while (E !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("reached_ehigh", E, 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_e", E, 0);
        chk("midrst_busy", Busy, 1);
        chk("midrst_d_out", D_out, 0);
        RESET = 1'b0;
        pq.delete();
        init_check();

        write_byte(8'hC0, 1'b0, 12, 0, 28, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
